// File: rtl/decode_stage.sv
// decode_stage: RV32I decode for OP-IMM, OP and LUI. Has a valid/ready handshake
// on both sides, a 2-entry in-order output buffer, and a pending-write scoreboard.
// The scoreboard stalls read-after-write hazards until the write is retired.

package decode_pkg;
    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_command_t;
endpackage

module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int EN_RTYPE  = 1,
    parameter int EN_SHIFTS = 1,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_inst_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [RA_W-1:0] out_rs1_addr_o,
    output logic [RA_W-1:0] out_rs2_addr_o,
    output logic [RA_W-1:0] out_rd_addr_o,
    output logic            out_rs1_en_o,
    output logic            out_rs2_en_o,
    output logic            out_rd_en_o,
    output logic            out_imm_sel_o,
    output logic [XLEN-1:0] out_imm_o,
    output alu_command_t    out_alu_op_o,
    output logic            out_illegal_o,
    input  logic            wb_valid_i,
    input  logic [RA_W-1:0] wb_addr_i,
    input  logic            flush_i
);

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam bit         SH_OK     = (EN_SHIFTS != 0);
    localparam bit         RT_OK     = (EN_RTYPE != 0);

    typedef struct packed {
        logic            illegal;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_en;
        logic            imm_sel;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] imm;
        alu_command_t    op;
    } entry_t;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    assign opc = in_inst_i[6:0];
    assign f3  = in_inst_i[14:12];
    assign f7  = in_inst_i[31:25];

    // Common funct3 -> ALU mapping shared by OP-IMM and OP (funct7 = 0 form)
    function automatic alu_command_t base_op(input logic [2:0] fn3);
        alu_command_t r;
        case (fn3)
            3'b000:  r = ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    entry_t dec;

    // Decode the presented instruction word. Unused register addresses are left at 0.
    always_comb begin
        dec         = '0;
        dec.op      = ALU_NONE;
        dec.illegal = 1'b1;
        case (opc)
            OPC_OPIMM: begin
                dec.illegal = 1'b0;
                dec.rs1_en  = 1'b1;
                dec.rd_en   = 1'b1;
                dec.imm_sel = 1'b1;
                dec.rs1     = in_inst_i[15 +: RA_W];
                dec.rd      = in_inst_i[7 +: RA_W];
                dec.imm     = XLEN'($signed(in_inst_i[31:20]));
                dec.op      = base_op(f3);
                if (f3 == 3'b001) begin
                    dec.illegal = !(SH_OK && f7 == 7'd0);
                end else if (f3 == 3'b101) begin
                    dec.op      = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    dec.imm     = XLEN'(in_inst_i[24:20]);
                    dec.illegal = !(SH_OK && (f7 == 7'd0 || f7 == F7_ALT));
                end
            end
            OPC_OP: begin
                dec.illegal = !RT_OK;
                dec.rs1_en  = 1'b1;
                dec.rs2_en  = 1'b1;
                dec.rd_en   = 1'b1;
                dec.rs1     = in_inst_i[15 +: RA_W];
                dec.rs2     = in_inst_i[20 +: RA_W];
                dec.rd      = in_inst_i[7 +: RA_W];
                if (f7 == 7'd0) begin
                    dec.op = base_op(f3);
                    if (f3 == 3'b001 || f3 == 3'b101)
                        dec.illegal = dec.illegal || !SH_OK;
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    dec.op = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    dec.op      = ALU_SRA;
                    dec.illegal = dec.illegal || !SH_OK;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.illegal = 1'b0;
                dec.rs1_en  = 1'b1;
                dec.rd_en   = 1'b1;
                dec.imm_sel = 1'b1;
                dec.rd      = in_inst_i[7 +: RA_W];
                dec.imm     = XLEN'($signed({in_inst_i[31:12], 12'b0}));
                dec.op      = ALU_ADD;
            end
            default: ;
        endcase
        // Illegal encodings carry no side effects downstream
        if (dec.illegal) begin
            dec         = '0;
            dec.op      = ALU_NONE;
            dec.illegal = 1'b1;
        end
    end

    entry_t                buf_q [2];
    entry_t                buf_d [2];
    logic [1:0]            count_q, count_d;
    logic [NUM_REGS-1:0]   sb_q, sb_d, sb_eff;
    logic                  hazard, rs1_busy, rs2_busy, issue, accept;

    // Hazard check. A writeback in this cycle already releases its register,
    // so the dependent instruction is accepted in the same cycle.
    always_comb begin
        sb_eff = sb_q;
        if (wb_valid_i) sb_eff[wb_addr_i] = 1'b0;
        rs1_busy = sb_eff[dec.rs1]
                || (count_q != 2'd0 && buf_q[0].rd_en && buf_q[0].rd == dec.rs1)
                || (count_q == 2'd2 && buf_q[1].rd_en && buf_q[1].rd == dec.rs1);
        rs2_busy = sb_eff[dec.rs2]
                || (count_q != 2'd0 && buf_q[0].rd_en && buf_q[0].rd == dec.rs2)
                || (count_q == 2'd2 && buf_q[1].rd_en && buf_q[1].rd == dec.rs2);
        hazard = (dec.rs1_en && dec.rs1 != '0 && rs1_busy)
              || (dec.rs2_en && dec.rs2 != '0 && rs2_busy);
    end

    assign out_valid_o = (count_q != 2'd0);
    assign in_ready_o  = (count_q != 2'd2) && !hazard && !flush_i;
    assign accept      = in_valid_i && in_ready_o;
    // A flushed head is discarded, not issued, so it never reaches the scoreboard
    assign issue       = out_valid_o && out_ready_i && !flush_i;

    // Next state of the FIFO and scoreboard. Entry 0 is always the head.
    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        sb_d    = sb_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (issue) buf_d[0] = buf_q[1];
            if (accept) begin
                if ((count_q - {1'b0, issue}) == 2'd0) buf_d[0] = dec;
                else                                   buf_d[1] = dec;
            end
            count_d = count_q + {1'b0, accept} - {1'b0, issue};
        end
        if (wb_valid_i) sb_d[wb_addr_i] = 1'b0;
        if (issue && buf_q[0].rd_en && buf_q[0].rd != '0) sb_d[buf_q[0].rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    // State registers; reset clears everything, including the head fields
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q  <= 2'd0;
            sb_q     <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            sb_q     <= sb_d;
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
        end
    end

    assign out_rs1_addr_o = buf_q[0].rs1;
    assign out_rs2_addr_o = buf_q[0].rs2;
    assign out_rd_addr_o  = buf_q[0].rd;
    assign out_rs1_en_o   = buf_q[0].rs1_en;
    assign out_rs2_en_o   = buf_q[0].rs2_en;
    assign out_rd_en_o    = buf_q[0].rd_en;
    assign out_imm_sel_o  = buf_q[0].imm_sel;
    assign out_imm_o      = buf_q[0].imm;
    assign out_alu_op_o   = buf_q[0].op;
    assign out_illegal_o  = buf_q[0].illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus random traffic for decode_stage.
// Expected values come from a reference model: a table decoder, a queue for
// the output buffer and a bit array for pending register writes.
`timescale 1ns/1ps
module tb_decode_stage;
    import decode_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [31:0]  in_inst_i;
    logic [4:0]   out_rs1_addr_o, out_rs2_addr_o, out_rd_addr_o, wb_addr_i;
    logic         out_rs1_en_o, out_rs2_en_o, out_rd_en_o, out_imm_sel_o, out_illegal_o;
    logic [31:0]  out_imm_o;
    alu_command_t out_alu_op_o;
    logic         wb_valid_i, flush_i;

    decode_stage #(.XLEN(32), .NUM_REGS(32), .EN_RTYPE(1), .EN_SHIFTS(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_inst_i(in_inst_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_rs1_addr_o(out_rs1_addr_o), .out_rs2_addr_o(out_rs2_addr_o),
        .out_rd_addr_o(out_rd_addr_o), .out_rs1_en_o(out_rs1_en_o),
        .out_rs2_en_o(out_rs2_en_o), .out_rd_en_o(out_rd_en_o),
        .out_imm_sel_o(out_imm_sel_o), .out_imm_o(out_imm_o),
        .out_alu_op_o(out_alu_op_o), .out_illegal_o(out_illegal_o),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit           ill, e1, e2, ed, isel;
        logic [4:0]   rs1, rs2, rd;
        logic [31:0]  imm;
        alu_command_t op;
    } mdl_t;

    localparam logic [31:0] ADDI_X1 = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] ADDI_X2 = 32'h00108113;  // addi x2,x1,1
    localparam logic [31:0] INST_A  = 32'h00100293;  // addi x5,x0,1
    localparam logic [31:0] INST_B  = 32'h00200313;  // addi x6,x0,2
    localparam logic [31:0] INST_C  = 32'h00300393;  // addi x7,x0,3
    localparam logic [31:0] SRAI    = 32'h40215193;  // srai x3,x2,2
    localparam logic [31:0] SUB     = 32'h40208033;  // sub x0,x1,x2
    localparam logic [31:0] MUL     = 32'h02208033;  // mul x0,x1,x2
    localparam logic [31:0] MUL_X1  = 32'h022080b3;  // mul x1,x1,x2
    localparam logic [31:0] RD_X5   = 32'h00028413;  // addi x8,x5,0

    mdl_t q[$];
    bit   sb[32];
    int   tests = 0, fails = 0;
    logic obs_rdy;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decoder, written as a set of legality rules plus a funct3 table
    function automatic mdl_t ref_dec(logic [31:0] w);
        alu_command_t tbl[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                 ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        mdl_t m;
        bit   ok;
        int   f3, f7;
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        ok = 0;
        m = '0;
        m.op = ALU_NONE;
        case (w[6:0])
            7'h13: begin
                ok = (f3 != 1 && f3 != 5) || (f3 == 1 && f7 == 0) ||
                     (f3 == 5 && (f7 == 0 || f7 == 32));
                m.op  = (f3 == 5 && f7 == 32) ? ALU_SRA : tbl[f3];
                m.imm = (f3 == 5) ? {27'b0, w[24:20]} : {{20{w[31]}}, w[31:20]};
                m.e1 = 1; m.ed = 1; m.isel = 1; m.rs1 = w[19:15]; m.rd = w[11:7];
            end
            7'h33: begin
                ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                m.op = (f7 == 32) ? ((f3 == 0) ? ALU_SUB : ALU_SRA) : tbl[f3];
                m.e1 = 1; m.e2 = 1; m.ed = 1;
                m.rs1 = w[19:15]; m.rs2 = w[24:20]; m.rd = w[11:7];
            end
            7'h37: begin
                ok = 1;
                m.e1 = 1; m.ed = 1; m.isel = 1; m.op = ALU_ADD;
                m.rs1 = 5'd0; m.rd = w[11:7]; m.imm = {w[31:12], 12'b0};
            end
            default: ;
        endcase
        if (!ok) begin
            m = '0;
            m.op = ALU_NONE;
            m.ill = 1;
        end
        return m;
    endfunction

    function automatic bit busy(logic [4:0] r, bit wbv, logic [4:0] wba);
        if (r == 5'd0) return 0;
        if (sb[r] && !(wbv && wba == r)) return 1;
        foreach (q[i]) if (q[i].ed && q[i].rd == r) return 1;
        return 0;
    endfunction

    // One clock: drive at negedge, check against the model, then advance the model at posedge
    task automatic step(bit inv, logic [31:0] inst, bit ordy, bit wbv, logic [4:0] wba, bit fl);
        mdl_t d;
        bit   exp_rdy, iss;
        @(negedge clk);
        in_valid_i = inv; in_inst_i = inst; out_ready_i = ordy;
        wb_valid_i = wbv; wb_addr_i = wba; flush_i = fl;
        #1;
        d = ref_dec(inst);
        exp_rdy = (q.size() < 2) && !fl &&
                  !((d.e1 && busy(d.rs1, wbv, wba)) || (d.e2 && busy(d.rs2, wbv, wba)));
        obs_rdy = in_ready_o;
        chk("in_ready", 32'(in_ready_o), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("head_illegal", 32'(out_illegal_o), 32'(q[0].ill));
            chk("head_rs1_en", 32'(out_rs1_en_o), 32'(q[0].e1));
            chk("head_rs2_en", 32'(out_rs2_en_o), 32'(q[0].e2));
            chk("head_rd_en", 32'(out_rd_en_o), 32'(q[0].ed));
            chk("head_imm_sel", 32'(out_imm_sel_o), 32'(q[0].isel));
            chk("head_imm", out_imm_o, q[0].imm);
            chk("head_op", 32'(out_alu_op_o), 32'(q[0].op));
            if (q[0].e1) chk("head_rs1", 32'(out_rs1_addr_o), 32'(q[0].rs1));
            if (q[0].e2) chk("head_rs2", 32'(out_rs2_addr_o), 32'(q[0].rs2));
            if (q[0].ed) chk("head_rd", 32'(out_rd_addr_o), 32'(q[0].rd));
        end
        @(posedge clk);
        iss = (q.size() != 0) && ordy && !fl;
        if (wbv) sb[wba] = 0;
        if (iss && q[0].ed && q[0].rd != 5'd0) sb[q[0].rd] = 1;
        if (fl) q.delete();
        else begin
            if (iss) void'(q.pop_front());
            if (inv && exp_rdy) q.push_back(d);
        end
    endtask

    task automatic do_reset(bit inv, logic [31:0] inst, bit fl, bit wbv);
        @(negedge clk);
        reset_n = 0; in_valid_i = inv; in_inst_i = inst; flush_i = fl;
        wb_valid_i = wbv; wb_addr_i = 5'd1; out_ready_i = 1;
        @(posedge clk);
        q.delete();
        foreach (sb[i]) sb[i] = 0;
        #1 reset_n = 1;
    endtask

    task automatic chk_reset();
        chk("rst_out_valid", 32'(out_valid_o), 0);
        chk("rst_rs1", 32'(out_rs1_addr_o), 0);
        chk("rst_rs2", 32'(out_rs2_addr_o), 0);
        chk("rst_rd", 32'(out_rd_addr_o), 0);
        chk("rst_ens", 32'({out_rs1_en_o, out_rs2_en_o, out_rd_en_o, out_imm_sel_o, out_illegal_o}), 0);
        chk("rst_imm", out_imm_o, 0);
        chk("rst_op", 32'(out_alu_op_o), 32'(ALU_NONE));
    endtask

    task automatic chk_illegal_head(string tag);
        chk({tag, "_illegal"}, 32'(out_illegal_o), 1);
        chk({tag, "_ens"}, 32'({out_rs1_en_o, out_rs2_en_o, out_rd_en_o, out_imm_sel_o}), 0);
        chk({tag, "_op"}, 32'(out_alu_op_o), 32'(ALU_NONE));
        chk({tag, "_imm"}, out_imm_o, 0);
    endtask

    // Empty the buffer, then retire every register so each scenario starts clean
    task automatic drain();
        for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 5'd0, 0);
        for (int r = 1; r < 32; r++) step(0, 32'h0, 0, 1, 5'(r), 0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          k;
        w = $urandom();
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        k = int'($urandom_range(0, 7));
        if (k <= 2) begin
            w[6:0] = 7'h13;
            if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end else if (k <= 5) begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 3))
                0, 1:    w[31:25] = 7'h00;
                2:       w[31:25] = 7'h20;
                default: w[31:25] = 7'h01;
            endcase
        end else if (k == 6) begin
            w[6:0] = 7'h37;
        end
        return w;
    endfunction

    bit          r_ordy, r_fl, r_inv, r_wbv;
    logic [4:0]  r_wba;

    initial begin
        reset_n = 0; in_valid_i = 0; in_inst_i = 0; out_ready_i = 0;
        wb_valid_i = 0; wb_addr_i = 0; flush_i = 0;
        do_reset(0, 32'h0, 0, 0);
        chk_reset();

        // Basic decode and one-cycle latency
        step(1, ADDI_X1, 1, 0, 5'd0, 0);
        chk("addi_accept", 32'(obs_rdy), 1);
        #1;
        chk("addi_valid", 32'(out_valid_o), 1);
        chk("addi_rd", 32'(out_rd_addr_o), 1);
        chk("addi_imm", out_imm_o, 5);
        chk("addi_op", 32'(out_alu_op_o), 32'(ALU_ADD));
        chk("addi_imm_sel", 32'(out_imm_sel_o), 1);
        chk("addi_rs1_en", 32'(out_rs1_en_o), 1);

        // RAW stall until writeback of x1, released in the writeback cycle
        step(1, ADDI_X2, 1, 0, 5'd0, 0);
        chk("raw_stall_buf", 32'(obs_rdy), 0);
        step(1, ADDI_X2, 0, 0, 5'd0, 0);
        chk("raw_stall_sb", 32'(obs_rdy), 0);
        step(1, ADDI_X2, 0, 1, 5'd1, 0);
        chk("raw_release", 32'(obs_rdy), 1);
        drain();

        // Backpressure and ordering
        step(1, INST_A, 0, 0, 5'd0, 0);
        step(1, INST_B, 0, 0, 5'd0, 0);
        step(1, INST_C, 0, 0, 5'd0, 0);
        chk("bp_full", 32'(obs_rdy), 0);
        #1 chk("bp_head_a", 32'(out_rd_addr_o), 5);
        step(1, INST_C, 1, 0, 5'd0, 0);
        chk("bp_full_issue", 32'(obs_rdy), 0);
        #1 chk("bp_head_b", 32'(out_rd_addr_o), 6);
        step(1, INST_C, 0, 0, 5'd0, 0);
        chk("bp_accept_c", 32'(obs_rdy), 1);
        #1 chk("bp_hold_b", 32'(out_rd_addr_o), 6);
        step(0, 32'h0, 1, 0, 5'd0, 0);
        #1 chk("bp_head_c", 32'(out_rd_addr_o), 7);
        drain();

        // Shift-immediate and R-type subtract
        step(1, SRAI, 0, 0, 5'd0, 0);
        #1;
        chk("srai_op", 32'(out_alu_op_o), 32'(ALU_SRA));
        chk("srai_imm", out_imm_o, 2);
        step(1, SUB, 1, 0, 5'd0, 0);
        #1;
        chk("sub_op", 32'(out_alu_op_o), 32'(ALU_SUB));
        chk("sub_rs2_en", 32'(out_rs2_en_o), 1);
        drain();

        // Illegal encodings pass through and leave the scoreboard alone
        step(1, 32'h0, 1, 0, 5'd0, 0);
        #1 chk_illegal_head("ill_zero");
        step(1, MUL, 1, 0, 5'd0, 0);
        #1 chk_illegal_head("ill_mul");
        step(1, MUL_X1, 1, 0, 5'd0, 0);
        step(0, 32'h0, 1, 0, 5'd0, 0);
        step(1, ADDI_X2, 0, 0, 5'd0, 0);
        chk("ill_no_sb", 32'(obs_rdy), 1);
        drain();

        // Flush of two buffered entries
        step(1, INST_A, 0, 0, 5'd0, 0);
        step(1, INST_B, 0, 0, 5'd0, 0);
        step(0, 32'h0, 0, 0, 5'd0, 1);
        #1 chk("flush_empty", 32'(out_valid_o), 0);
        step(1, RD_X5, 0, 0, 5'd0, 0);
        chk("flush_no_sb", 32'(obs_rdy), 1);
        drain();

        // Reset mid-operation beats flush, handshake and writeback
        step(1, ADDI_X1, 1, 0, 5'd0, 0);
        step(1, INST_A, 1, 0, 5'd0, 0);
        step(1, INST_B, 0, 0, 5'd0, 0);
        do_reset(1, INST_C, 1, 1);
        chk_reset();
        step(1, ADDI_X2, 0, 0, 5'd0, 0);
        chk("rst_sb_clear", 32'(obs_rdy), 1);
        drain();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            r_ordy = ($urandom_range(0, 9) < 6);
            r_fl   = !r_ordy && ($urandom_range(0, 29) == 0);
            r_inv  = ($urandom_range(0, 9) < 7);
            r_wbv  = ($urandom_range(0, 9) < 4);
            r_wba  = 5'($urandom_range(0, 7));
            step(r_inv, rand_inst(), r_ordy, r_wbv, r_wba, r_fl);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
